// File: rtl/dct2d_pkg.sv
// Shared constants and FSM state type for the 8x8 forward DCT engine.
package dct2d_pkg;
    localparam int N         = 8;
    localparam int DW        = 16;
    localparam int COEF_FRAC = 14;
    localparam int ACC_W     = 35;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
endpackage

// File: rtl/dct_mac.sv
// Clear/accumulate MAC with round-half-up, shift by COEF_FRAC and 16-bit reduction.
// Build option DCT2D_SATURATE_EN selects saturation instead of wrap-around truncation.
module dct_mac
    import dct2d_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_en,
    input  logic                 clr,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_FRAC - 1);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;

    // y reflects the sum including the current product, so the final term
    // can be captured on the same edge that would otherwise clear the accumulator.
`ifdef DCT2D_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        prod    = a * b;
        acc_sum = (clr ? '0 : acc) + ACC_W'(prod);
        shifted = (acc_sum + HALF) >>> COEF_FRAC;
        if (shifted > SAT_MAX)
            y = 16'sh7FFF;
        else if (shifted < SAT_MIN)
            y = 16'sh8000;
        else
            y = shifted[DW-1:0];
    end
`else
    always_comb begin
        prod    = a * b;
        acc_sum = (clr ? '0 : acc) + ACC_W'(prod);
        y       = DW'((acc_sum + HALF) >>> COEF_FRAC);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (acc_en)
            acc <= acc_sum;
    end
endmodule

// File: rtl/dct_2d.sv
// 8x8 forward DCT, Y = C*X*C^T, two sequential passes through one MAC with an internal T buffer.
// Optional build macro DCT2D_SATURATE_EN (in dct_mac) saturates each pass result.
module dct_2d
    import dct2d_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 rdy,
    output logic [5:0]           iaddr,
    input  logic signed [DW-1:0] iq,
    output logic [5:0]           maddr,
    input  logic signed [DW-1:0] mq,
    output logic [5:0]           waddr,
    output logic signed [DW-1:0] wdata,
    output logic                 wwren
);
    state_t state, state_nxt;

    // cnt = {done, pass, i, j, k}: one address issued per cycle across both passes.
    logic [10:0] cnt;
    logic [2:0]  i, j, k;
    logic        issuing;
    logic [5:0]  taddr;

    logic        d1_valid, d1_first, d1_last, d1_pass2;
    logic [5:0]  d1_idx;

    logic signed [DW-1:0] tbuf [N*N];
    logic signed [DW-1:0] t_q;
    logic signed [DW-1:0] mac_a, mac_y;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        i       = cnt[8:6];
        j       = cnt[5:3];
        k       = cnt[2:0];
        issuing = (state == PASS1 || state == PASS2) && !cnt[10];
        iaddr   = {k, j};
        maddr   = cnt[9] ? {j, k} : {i, k};
        taddr   = {i, k};
        rdy     = (state == IDLE);
        mac_a   = d1_pass2 ? t_q : iq;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = PASS1;
            PASS1:   if (cnt == 11'd511) state_nxt = PASS2;
            PASS2:   if (wwren && waddr == 6'd63) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            d1_valid <= 1'b0;
            d1_first <= 1'b0;
            d1_last  <= 1'b0;
            d1_pass2 <= 1'b0;
            d1_idx   <= '0;
            wwren    <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                cnt <= '0;
            else if (issuing)
                cnt <= cnt + 11'd1;

            // Data stage lags the address stage by the one-cycle RAM latency.
            d1_valid <= issuing;
            d1_first <= (k == 3'd0);
            d1_last  <= (k == 3'd7);
            d1_pass2 <= cnt[9];
            d1_idx   <= {i, j};

            wwren <= d1_valid && d1_last && d1_pass2;
            if (d1_valid && d1_last && d1_pass2) begin
                waddr <= d1_idx;
                wdata <= mac_y;
            end
        end
    end

    // NOTE: the T buffer is scratch storage fully rewritten each run, so it carries no reset.
    always_ff @(posedge clk) begin
        t_q <= tbuf[taddr];
        if (d1_valid && d1_last && !d1_pass2)
            tbuf[d1_idx] <= mac_y;
    end

    dct_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .acc_en (d1_valid),
        .clr    (d1_first),
        .a      (mac_a),
        .b      (mq),
        .y      (mac_y)
    );
endmodule

// File: tb/tb_dct_2d.sv
// Directed self-checking bench for dct_2d: reset, flat, DC, impulse, abort, back-to-back, saturation.
module tb_dct_2d;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               en = 1'b0;
    logic               rdy;
    logic [5:0]         iaddr, maddr, waddr;
    logic signed [15:0] iq, mq, wdata;
    logic               wwren;

    logic signed [15:0] xmem [64];
    logic signed [15:0] cmem [64];
    logic signed [15:0] ybuf [64];

    int nwrites, order_err, exp_addr;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dct_2d dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .rdy   (rdy),
        .iaddr (iaddr),
        .iq    (iq),
        .maddr (maddr),
        .mq    (mq),
        .waddr (waddr),
        .wdata (wdata),
        .wwren (wwren)
    );

    // Synchronous RAMs with one-cycle read latency.
    always @(posedge clk) begin
        iq <= xmem[iaddr];
        mq <= cmem[maddr];
    end

    // Output RAM capture and write-order monitor.
    always @(negedge clk) begin
        if (wwren) begin
            ybuf[waddr] = wdata;
            if (int'(waddr) != exp_addr) order_err++;
            exp_addr++;
            nwrites++;
        end
    end

    function automatic int rnd(real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic real rabs(real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic init_coef();
        real v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (r == 0) v = 16384.0 * $sqrt(0.125);
                else        v = 8192.0 * $cos((2.0 * c + 1.0) * r * 3.14159265358979 / 16.0);
                cmem[8*r+c] = 16'(rnd(v));
            end
    endtask

    task automatic fill_x(input logic signed [15:0] v);
        for (int a = 0; a < 64; a++) xmem[a] = v;
    endtask

    task automatic clear_mon();
        nwrites = 0; order_err = 0; exp_addr = 0;
        for (int a = 0; a < 64; a++) ybuf[a] = 16'sh5555;
    endtask

    task automatic wait_rdy(input string tag, output int busy);
        busy = 0;
        while (!rdy && busy < 1200) begin
            busy++;
            @(negedge clk);
        end
        checks++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: rdy=%b after %0d cycles, required 1", tag, rdy, busy);
        end
    endtask

    task automatic run_block(input string tag, output int busy);
        clear_mon();
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        wait_rdy(tag, busy);
    endtask

    task automatic check_count(input string tag);
        checks++;
        if (nwrites !== 64 || order_err !== 0) begin
            fails++;
            $display("FAIL %s_writes: got %0d writes with %0d out of order, required 64 ascending", tag, nwrites, order_err);
        end
    endtask

    task automatic check_impulse(input string tag);
        int bad = 0;
        real model;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                model = 100.0 * (cmem[8*u] / 16384.0) * (cmem[8*v] / 16384.0);
                if (rabs(real'(ybuf[8*u+v]) - model) > 1.0) bad++;
            end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL %s_values: %0d coefficients off model by more than 1, required 0", tag, bad);
        end
        checks++;
        if (ybuf[0] < 11 || ybuf[0] > 14) begin
            fails++;
            $display("FAIL %s_y00: got %0d, required 11..14", tag, ybuf[0]);
        end
    endtask

    task automatic check_dc(input string tag);
        int bad = 0;
        checks++;
        if (ybuf[0] < 1015 || ybuf[0] > 1017) begin
            fails++;
            $display("FAIL %s_y00: got %0d, required 1015..1017", tag, ybuf[0]);
        end
        for (int a = 1; a < 64; a++)
            if (ybuf[a] > 1 || ybuf[a] < -1) bad++;
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL %s_ac: %0d AC coefficients beyond +/-1, required 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || wwren !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: rdy=%b wwren=%b, required rdy=1 wwren=0", rdy, wwren);
        end
        checks++;
        if (iaddr !== 6'd0 || maddr !== 6'd0 || waddr !== 6'd0) begin
            fails++;
            $display("FAIL reset_addr: iaddr=%0d maddr=%0d waddr=%0d, required 0", iaddr, maddr, waddr);
        end
        checks++;
        if (wdata !== 16'sd0) begin
            fails++;
            $display("FAIL reset_wdata: got %0d, required 0", wdata);
        end
    endtask

    task automatic test_flat();
        int busy, nz = 0;
        fill_x(16'sd0);
        run_block("flat", busy);
        check_count("flat");
        for (int a = 0; a < 64; a++) if (ybuf[a] !== 16'sd0) nz++;
        checks++;
        if (nz !== 0) begin
            fails++;
            $display("FAIL flat_values: %0d nonzero coefficients, required 0", nz);
        end
        checks++;
        if (busy > 1100 || busy < 1) begin
            fails++;
            $display("FAIL flat_busy: busy %0d cycles, required 1..1100", busy);
        end
    endtask

    task automatic test_dc();
        int busy;
        fill_x(16'sd127);
        run_block("dc", busy);
        check_count("dc");
        check_dc("dc");
    endtask

    task automatic test_impulse();
        int busy;
        fill_x(16'sd0);
        xmem[0] = 16'sd100;
        run_block("impulse", busy);
        check_count("impulse");
        check_impulse("impulse");
    endtask

    task automatic test_abort();
        int busy, n0;
        fill_x(16'sd0);
        xmem[0] = 16'sd100;
        clear_mon();
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || wwren !== 1'b0) begin
            fails++;
            $display("FAIL abort_ctrl: rdy=%b wwren=%b, required rdy=1 wwren=0", rdy, wwren);
        end
        reset = 1'b0;
        n0 = nwrites;
        repeat (20) @(negedge clk);
        checks++;
        if (nwrites !== n0 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL abort_idle: writes %0d->%0d rdy=%b, required no writes and rdy=1", n0, nwrites, rdy);
        end
        run_block("abort_rerun", busy);
        check_count("abort_rerun");
        check_impulse("abort_rerun");
    endtask

    task automatic test_back_to_back();
        int busy;
        fill_x(16'sd127);
        clear_mon();
        @(negedge clk) en = 1'b1;
        @(negedge clk);
        wait_rdy("b2b_first", busy);
        check_count("b2b_first");
        clear_mon();
        @(negedge clk);
        checks++;
        if (rdy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: rdy=%b, required 0 with en held", rdy);
        end
        en = 1'b0;
        wait_rdy("b2b_second", busy);
        check_count("b2b_second");
        check_dc("b2b_second");
    endtask

`ifdef DCT2D_SATURATE_EN
    task automatic test_saturation();
        int busy;
        fill_x(16'sh7FFF);
        run_block("sat", busy);
        checks++;
        if (ybuf[0] !== 16'sh7FFF) begin
            fails++;
            $display("FAIL sat_y00: got %0d, required 32767", ybuf[0]);
        end
    endtask
`endif

    initial begin
        init_coef();
        fill_x(16'sd0);
        clear_mon();
        test_reset();
        test_flat();
        test_dc();
        test_impulse();
        test_abort();
        test_back_to_back();
`ifdef DCT2D_SATURATE_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
